// File: rtl/comm_activity_detector.sv
// comm_activity_detector: synchronises raw bus lines, detects edges and
// stretches activity into an LED-friendly comm_active flag with a debug count.
module comm_activity_detector #(
   parameter int NUM_LINES    = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int IDLE_TIMEOUT = 1_000,
   parameter int MIN_ON_COUNT = 100_000,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic [NUM_LINES-1:0]   bus_lines,
   input  logic                   enable,
   input  logic                   clear_count,
   output logic                   comm_active,
   output logic                   activity_pulse,
   output logic [COUNT_WIDTH-1:0] edge_count
);

   localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);
   localparam int ON_W    = $clog2(MIN_ON_COUNT + 1);
   localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

   localparam logic [IDLE_W-1:0]      IDLE_LOAD  = IDLE_W'(IDLE_TIMEOUT);
   localparam logic [IDLE_W-1:0]      IDLE_ONE   = IDLE_W'(1);
   localparam logic [ON_W-1:0]        ON_LOAD    = ON_W'(MIN_ON_COUNT);
   localparam logic [ON_W-1:0]        ON_ONE     = ON_W'(1);
   localparam logic [PRIME_W-1:0]     PRIME_LAST = PRIME_W'(SYNC_STAGES);
   localparam logic [PRIME_W-1:0]     PRIME_ONE  = PRIME_W'(1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;
   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   logic [NUM_LINES-1:0] sync_chain [SYNC_STAGES];
   logic [NUM_LINES-1:0] prev_lines;
   logic [PRIME_W-1:0]   prime_cnt;
   logic                 primed;
   logic                 edge_hit;
   state_t               state;
   logic [IDLE_W-1:0]    idle_cnt;
   logic [ON_W-1:0]      on_cnt;
   logic [ON_W-1:0]      on_next;
   logic                 idle_done;
   logic                 on_done;

   // multi-flop synchroniser per line
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_chain[i] <= '0;
         end
      end else begin
         sync_chain[0] <= bus_lines;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_chain[i] <= sync_chain[i-1];
         end
      end
   end

   // previous synchronised sample, tracked even while disabled
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         prev_lines <= '0;
      end else begin
         prev_lines <= sync_chain[SYNC_STAGES-1];
      end
   end

   // mask edges until the chain and prev hold real line samples
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         prime_cnt <= '0;
         primed    <= 1'b0;
      end else if (!primed) begin
         prime_cnt <= prime_cnt + PRIME_ONE;
         primed    <= (prime_cnt == PRIME_LAST);
      end
   end

   // any line change in this cycle counts as a single edge
   always_comb begin
      edge_hit = primed & enable
               & (|(sync_chain[SYNC_STAGES-1] ^ prev_lines));
   end

   // counter helpers; "done" means the count expires at this clock
   always_comb begin
      on_next   = (on_cnt == '0) ? '0 : on_cnt - ON_ONE;
      on_done   = (on_cnt <= ON_ONE);
      idle_done = (idle_cnt <= IDLE_ONE);
   end

   // activity stretching FSM with registered outputs
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state          <= IDLE;
         comm_active    <= 1'b0;
         activity_pulse <= 1'b0;
         idle_cnt       <= '0;
         on_cnt         <= '0;
      end else if (!enable) begin
         state          <= IDLE;
         comm_active    <= 1'b0;
         activity_pulse <= 1'b0;
         idle_cnt       <= '0;
         on_cnt         <= '0;
      end else begin
         activity_pulse <= edge_hit;
         unique case (state)
            IDLE: begin
               if (edge_hit) begin
                  state       <= ACTIVE;
                  comm_active <= 1'b1;
                  idle_cnt    <= IDLE_LOAD;
                  on_cnt      <= ON_LOAD;
               end
            end
            ACTIVE: begin
               on_cnt <= on_next;
               if (edge_hit) begin
                  idle_cnt <= IDLE_LOAD;
               end else if (idle_done) begin
                  idle_cnt <= '0;
                  if (on_done) begin
                     state       <= IDLE;
                     comm_active <= 1'b0;
                  end else begin
                     state <= HOLD;
                  end
               end else begin
                  idle_cnt <= idle_cnt - IDLE_ONE;
               end
            end
            HOLD: begin
               on_cnt <= on_next;
               if (edge_hit) begin
                  state    <= ACTIVE;
                  idle_cnt <= IDLE_LOAD;
               end else if (on_done) begin
                  state       <= IDLE;
                  comm_active <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               comm_active <= 1'b0;
               idle_cnt    <= '0;
               on_cnt      <= '0;
            end
         endcase
      end
   end

   // saturating debug count of edge cycles; clear wins over increment
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         edge_count <= '0;
      end else if (clear_count) begin
         edge_count <= '0;
      end else if (edge_hit && (edge_count != COUNT_MAX)) begin
         edge_count <= edge_count + COUNT_ONE;
      end
   end

endmodule
